// File: rtl/cim_level_seq.sv
// Sequential continuous-item-memory level generator: derives level k from the seed by
// inverting the top k*FlipsPerLevel bits, one level step per clock.
module cim_level_seq #(
    parameter int unsigned HVDimension   = 512,
    parameter int unsigned NumLevels     = 21,
    parameter int unsigned FlipsPerLevel = 12,
    parameter int unsigned LevelWidth    = $clog2(NumLevels)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [HVDimension-1:0] seed_hv_i,
    input  logic [LevelWidth-1:0]  req_level_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    output logic [HVDimension-1:0] hv_o,
    output logic                   hv_valid_o,
    input  logic                   hv_ready_i
);

    typedef enum logic [1:0] {
        StIdle,
        StCompute,
        StOutput
    } state_e;

    localparam logic [LevelWidth-1:0] MaxLevel = LevelWidth'(NumLevels - 1);

    function automatic logic [HVDimension-1:0] gen_top_mask();
        logic [HVDimension-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < FlipsPerLevel; i++) begin
            m[HVDimension-1-i] = 1'b1;
        end
        return m;
    endfunction

    // Mask for the first level step; later steps are this shifted down by whole levels.
    localparam logic [HVDimension-1:0] TopMask = gen_top_mask();

    state_e                 state;
    logic [HVDimension-1:0] work_hv;
    logic [LevelWidth-1:0]  step_cnt;
    logic [LevelWidth-1:0]  target;

    logic [LevelWidth-1:0]  req_target;
    logic [LevelWidth-1:0]  step_next;
    logic [31:0]            shift_amt;
    logic [HVDimension-1:0] flip_mask;
    logic [HVDimension-1:0] work_next;

    always_comb begin
        req_target = (req_level_i > MaxLevel) ? MaxLevel : req_level_i;
        step_next  = step_cnt + LevelWidth'(1);
        shift_amt  = 32'(step_cnt) * 32'(FlipsPerLevel);
        flip_mask  = TopMask >> shift_amt;
        work_next  = work_hv ^ flip_mask;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= StIdle;
            work_hv     <= '0;
            hv_o        <= '0;
            hv_valid_o  <= 1'b0;
            req_ready_o <= 1'b1;
            step_cnt    <= '0;
            target      <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (req_valid_i && req_ready_o) begin
                        work_hv     <= seed_hv_i;
                        target      <= req_target;
                        step_cnt    <= '0;
                        req_ready_o <= 1'b0;
                        if (req_target == '0) begin
                            hv_o       <= seed_hv_i;
                            hv_valid_o <= 1'b1;
                            state      <= StOutput;
                        end else begin
                            state <= StCompute;
                        end
                    end
                end
                StCompute: begin
                    work_hv  <= work_next;
                    step_cnt <= step_next;
                    if (step_next == target) begin
                        hv_o       <= work_next;
                        hv_valid_o <= 1'b1;
                        state      <= StOutput;
                    end
                end
                StOutput: begin
                    if (hv_ready_i) begin
                        hv_valid_o  <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= StIdle;
                    end
                end
                default: begin
                    hv_valid_o  <= 1'b0;
                    req_ready_o <= 1'b1;
                    state       <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cim_level_seq.sv
// Scoreboard bench for cim_level_seq: the driver queues expected results, a monitor checks
// latency and value on every output presentation.
module tb_cim_level_seq;

    localparam int Hvd = 512;

    typedef struct {
        logic [Hvd-1:0] hv;
        int             cyc;
        int             lvl;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [Hvd-1:0] seed_hv;
    logic [4:0]     req_level;
    logic           req_valid;
    logic           req_ready;
    logic [Hvd-1:0] hv;
    logic           hv_valid;
    logic           hv_ready;

    cim_level_seq dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .seed_hv_i  (seed_hv),
        .req_level_i(req_level),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .hv_o       (hv),
        .hv_valid_o (hv_valid),
        .hv_ready_i (hv_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int             tests = 0;
    int             fails = 0;
    exp_t           q[$];
    logic [Hvd-1:0] res[0:20];
    logic           prev_valid = 1'b0;

    task automatic check(input string name, input logic [Hvd-1:0] act, input logic [Hvd-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [Hvd-1:0] model_hv(input logic [Hvd-1:0] s, input int k);
        logic [Hvd-1:0] m;
        m = '0;
        for (int i = 0; i < 12 * k; i++) m[Hvd-1-i] = 1'b1;
        return s ^ m;
    endfunction

    function automatic logic [Hvd-1:0] rand_hv();
        logic [Hvd-1:0] r;
        for (int i = 0; i < Hvd / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Monitor: latency on the rising edge of valid, value on each handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (hv_valid && !prev_valid) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid: got valid with nothing outstanding, required none");
                end else begin
                    check("latency_cycle", Hvd'(cyc), Hvd'(q[0].cyc));
                end
            end
            if (hv_valid && hv_ready && q.size() != 0) begin
                e = q.pop_front();
                check($sformatf("hv_lvl%0d", e.lvl), hv, e.hv);
                if (e.lvl >= 0 && e.lvl <= 20) res[e.lvl] = hv;
            end
            prev_valid = hv_valid;
        end
    end

    task automatic issue(input logic [Hvd-1:0] s, input logic [4:0] lvl,
                         input logic [Hvd-1:0] exp_hv, input int lat, input int tag,
                         input bit expect_out);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got req_ready=0, required 1");
        end
        seed_hv   = s;
        req_level = lvl;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        if (expect_out) q.push_back('{hv: exp_hv, cyc: cyc + lat, lvl: tag});
        check("ready_low_after_accept", Hvd'(req_ready), Hvd'(0));
        req_valid = 1'b0;
        // Disturb inputs after accept; the in-flight computation must not see this.
        seed_hv   = ~s;
        req_level = 5'd7;
    endtask

    task automatic wait_done();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL result_timeout: got %0d outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [Hvd-1:0] r;
        logic [Hvd-1:0] e;
        int             n;

        rst       = 1'b1;
        seed_hv   = '0;
        req_level = '0;
        req_valid = 1'b0;
        hv_ready  = 1'b1;
        #12;
        check("rst_hv", hv, '0);
        check("rst_valid", Hvd'(hv_valid), Hvd'(0));
        check("rst_ready", Hvd'(req_ready), Hvd'(1));
        @(negedge clk);
        rst = 1'b0;

        // Level 0 and level 1 from a zero seed.
        issue('0, 5'd0, '0, 0, -1, 1'b1);
        wait_done();
        issue('0, 5'd1, {{12{1'b1}}, {500{1'b0}}}, 1, -1, 1'b1);
        wait_done();

        // Top level and clamped out-of-range level from an all-ones seed.
        issue('1, 5'd20, {{240{1'b0}}, {272{1'b1}}}, 20, -1, 1'b1);
        wait_done();
        issue('1, 5'd31, {{240{1'b0}}, {272{1'b1}}}, 20, -1, 1'b1);
        wait_done();

        // Backpressure: output held for 5 cycles, a stray request must be ignored.
        r = rand_hv();
        e = r ^ {{36{1'b1}}, {476{1'b0}}};
        hv_ready = 1'b0;
        issue(r, 5'd3, e, 3, -1, 1'b1);
        n = 0;
        while (!hv_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_hv_%0d", i), hv, e);
            check($sformatf("bp_valid_%0d", i), Hvd'(hv_valid), Hvd'(1));
            check($sformatf("bp_ready_%0d", i), Hvd'(req_ready), Hvd'(0));
            if (i == 2) begin
                seed_hv   = '0;
                req_level = 5'd0;
                req_valid = 1'b1;
            end
            if (i == 3) req_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        hv_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_ready", Hvd'(req_ready), Hvd'(1));
        check("bp_idle_valid", Hvd'(hv_valid), Hvd'(0));
        check("bp_idle_hv_kept", hv, e);
        wait_done();

        // Reset in the 6th COMPUTE cycle of a level-15 request.
        r = rand_hv();
        issue(r, 5'd15, '0, 0, -1, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", Hvd'(hv_valid), Hvd'(0));
        check("midrst_hv", hv, '0);
        check("midrst_ready", Hvd'(req_ready), Hvd'(1));
        @(negedge clk);
        rst = 1'b0;
        issue(r, 5'd2, r ^ {{24{1'b1}}, {488{1'b0}}}, 2, -1, 1'b1);
        wait_done();

        // Distance sweep over all levels from one random seed.
        r = rand_hv();
        for (int k = 0; k <= 20; k++) begin
            issue(r, 5'(k), model_hv(r, k), k, k, 1'b1);
            wait_done();
        end
        for (int i = 0; i <= 20; i++) begin
            check($sformatf("sweep_pop_%0d", i), Hvd'($countones(res[i] ^ r)), Hvd'(12 * i));
            for (int j = i + 1; j <= 20; j++) begin
                check($sformatf("ham_%0d_%0d", i, j), Hvd'($countones(res[i] ^ res[j])),
                      Hvd'(12 * (j - i)));
            end
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
